i2s_rx_sampler: RTL
===================

// Module: i2s_rx_sampler
// PURPOSE
//   Recovers stereo PCM from WM8731 ADC bit stream (BCLK/ADCLRCK/ADCDAT, I2S mode) by
//   oversampling in the 50 MHz domain; first stage of the audio path, feeding the
//   overflow-reduce / DSP / visual holders with an L/R pair plus a one-cycle strobe.
//   Replaces BCLK-clocked capture so downstream logic runs on a single clock.
// PARAMETERS
//   WS           16  audio word size in bits (signed, MSB first)
//   SYNC_STAGES   2  synchronizer flops on iBCLK/iLRCK/iDAT (>=2)
//   ERR_W         8  width of saturating frame-error counter
// PORTS
//   iCLK_50      in   1        system clock, 50 MHz
//   iRST         in   1        asynchronous reset, active high
//   iBCLK        in   1        codec bit clock (async to iCLK_50)
//   iLRCK        in   1        codec ADC LR clock; low = left, high = right
//   iDAT         in   1        codec ADC serial data
//   oL           out  WS       left sample, signed, held until next oVALID
//   oR           out  WS       right sample, signed, held until next oVALID
//   oVALID       out  1        one-cycle strobe: oL/oR updated this cycle
//   oFRAME_ERR   out  1        one-cycle strobe: short/aborted channel word
//   oERR_CNT     out  ERR_W    saturating count of oFRAME_ERR strobes
// BEHAVIOUR
//   Reset (async assert, sync release): oL=oR=0, oVALID=0, oFRAME_ERR=0, oERR_CNT=0,
//     synchronizers cleared, FSM=IDLE, staging/shift regs 0. Partial words discarded.
//   Sampling: iBCLK/iLRCK/iDAT each pass SYNC_STAGES flops; BCLK rise = synced cur 1,
//     prev 0. LRCK and DAT are taken from the same synced sample as the BCLK rise.
//     Requires BCLK high and low phases >= 2 iCLK_50 cycles each.
//   LRCK edge = LRCK value at this BCLK rise differs from value at previous BCLK rise.
//   FSM (advances only on BCLK rise):
//     IDLE  : wait for first LRCK edge -> SKIP (no output from partial first frame).
//     SKIP  : I2S 1-bit delay; this rise carries no data -> SHIFT, bitcnt=0.
//     SHIFT : shift DAT into LSB of shift reg, bitcnt++; at bitcnt==WS-1 word complete
//             -> DONE. Left word (chan=0) -> staging reg, left_ok=1.
//             Right word (chan=1): if left_ok then oL<=staging, oR<=word, oVALID=1;
//             left_ok=0 either way.
//     DONE  : ignore further bits (slots longer than WS) until LRCK edge -> SKIP.
//   Channel of a word = LRCK level latched at the LRCK edge that started it.
//   LRCK edge while in SHIFT (fewer than WS bits): discard word, oFRAME_ERR=1 one cycle,
//     oERR_CNT+1 (saturates at all-ones), left_ok=0, -> SKIP for new channel.
//   LRCK edge in SKIP (zero-length slot) treated the same as in SHIFT.
//   Right word completing with left_ok=0: no oVALID, no error (startup/resync case).
//   Latency: oVALID asserts in iCLK_50 cycle after the cycle that detects the BCLK rise
//     carrying right LSB; oL/oR change only in that cycle.
//   oVALID and oFRAME_ERR never asserted in the same cycle.
//   No arithmetic on samples: bit-exact two's complement copy, no sign extension.
// TESTING
//   1) Reset, then 3 I2S frames L=16'h8001, R=16'h7FFE, BCLK=50/16 MHz -> oVALID pulses
//      once per frame from frame 2 on, oL=16'h8001, oR=16'h7FFE, oERR_CNT=0.
//   2) 32-bit slots (16 data + 16 pad bits of 1s), L=16'h1234 R=16'hABCD -> pad ignored,
//      oL=16'h1234, oR=16'hABCD.
//   3) Left slot cut to 9 bits by early LRCK edge -> one oFRAME_ERR, oERR_CNT=1, no
//      oVALID for that frame, next clean frame gives oVALID with correct data.
//   4) 300 consecutive short slots -> oERR_CNT saturates at 8'hFF, no wrap.
//   5) Assert iRST mid-right-word after a good left word -> outputs 0 immediately;
//      first oVALID only after a complete new L+R frame, never with pre-reset left.
//   6) BCLK at minimum (2 high/2 low iCLK_50 cycles) with iBCLK/iLRCK skewed 1 cycle
//      -> data bit-exact over 1000 random frames vs. reference model.

Source files
------------

// File: rtl/i2s_rx_sampler.sv
// rtl/i2s_rx_sampler.sv - I2S ADC receiver oversampled in the 50 MHz domain
// Emits an L/R pair with a one-cycle strobe; short slots raise a frame-error strobe.
module i2s_rx_sampler #(
    parameter int WS          = 16,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_W       = 8
) (
    input  logic             iCLK_50,
    input  logic             iRST,
    input  logic             iBCLK,
    input  logic             iLRCK,
    input  logic             iDAT,
    output logic [WS-1:0]    oL,
    output logic [WS-1:0]    oR,
    output logic             oVALID,
    output logic             oFRAME_ERR,
    output logic [ERR_W-1:0] oERR_CNT
);

    localparam int CW = (WS > 2) ? $clog2(WS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_SHIFT, S_DONE} state_t;

    logic [1:0]             r_rst_pipe;
    logic                   w_rst;
    logic [SYNC_STAGES-1:0] r_bclk_sync;
    logic [SYNC_STAGES-1:0] r_lrck_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_bclk_prev;
    logic                   r_lrck_last;
    logic                   r_lrck_seen;
    state_t                 r_state;
    logic                   r_chan;
    logic [CW-1:0]          r_bitcnt;
    logic [WS-2:0]          r_shift;
    logic [WS-1:0]          r_stage;
    logic                   r_left_ok;
    logic [WS-1:0]          r_l;
    logic [WS-1:0]          r_r;
    logic                   r_valid;
    logic                   r_ferr;
    logic [ERR_W-1:0]       r_err_cnt;

    logic                   w_bclk;
    logic                   w_lrck;
    logic                   w_dat;
    logic                   w_rise;
    logic                   w_edge;
    logic [WS-1:0]          w_word;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge iCLK_50 or posedge iRST) begin
        if (iRST) r_rst_pipe <= 2'b11;
        else      r_rst_pipe <= {r_rst_pipe[0], 1'b0};
    end
    assign w_rst = r_rst_pipe[1];

    assign w_bclk = r_bclk_sync[SYNC_STAGES-1];
    assign w_lrck = r_lrck_sync[SYNC_STAGES-1];
    assign w_dat  = r_dat_sync[SYNC_STAGES-1];
    assign w_rise = w_bclk & ~r_bclk_prev;
    // The very first observed rise only primes r_lrck_last; it cannot be an edge.
    assign w_edge = w_rise & r_lrck_seen & (w_lrck != r_lrck_last);
    assign w_word = {r_shift, w_dat};

    always_ff @(posedge iCLK_50 or posedge w_rst) begin
        if (w_rst) begin
            r_bclk_sync <= '0;
            r_lrck_sync <= '0;
            r_dat_sync  <= '0;
            r_bclk_prev <= 1'b0;
            r_lrck_last <= 1'b0;
            r_lrck_seen <= 1'b0;
            r_state     <= S_IDLE;
            r_chan      <= 1'b0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_stage     <= '0;
            r_left_ok   <= 1'b0;
            r_l         <= '0;
            r_r         <= '0;
            r_valid     <= 1'b0;
            r_ferr      <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], iBCLK};
            r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], iLRCK};
            r_dat_sync  <= {r_dat_sync[SYNC_STAGES-2:0], iDAT};
            r_bclk_prev <= w_bclk;
            r_valid     <= 1'b0;
            r_ferr      <= 1'b0;
            if (w_rise) begin
                r_lrck_last <= w_lrck;
                r_lrck_seen <= 1'b1;
                if (w_edge) begin
                    r_chan   <= w_lrck;
                    r_state  <= S_SKIP;
                    r_bitcnt <= '0;
                    if (r_state == S_SKIP || r_state == S_SHIFT) begin
                        r_ferr    <= 1'b1;
                        r_left_ok <= 1'b0;
                        if (r_err_cnt != {ERR_W{1'b1}})
                            r_err_cnt <= r_err_cnt + ERR_W'(1);
                    end
                end else begin
                    case (r_state)
                        S_SKIP: begin
                            r_state  <= S_SHIFT;
                            r_bitcnt <= '0;
                        end
                        S_SHIFT: begin
                            r_shift  <= w_word[WS-2:0];
                            r_bitcnt <= r_bitcnt + CW'(1);
                            if (r_bitcnt == CW'(WS-1)) begin
                                r_state <= S_DONE;
                                if (!r_chan) begin
                                    r_stage   <= w_word;
                                    r_left_ok <= 1'b1;
                                end else begin
                                    if (r_left_ok) begin
                                        r_l     <= r_stage;
                                        r_r     <= w_word;
                                        r_valid <= 1'b1;
                                    end
                                    r_left_ok <= 1'b0;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign oL         = r_l;
    assign oR         = r_r;
    assign oVALID     = r_valid;
    assign oFRAME_ERR = r_ferr;
    assign oERR_CNT   = r_err_cnt;

endmodule
